// File: rtl/cpu_pkg.sv
// Shared CPU widths and typedefs for select codes and their decoded one-hot words.
package cpu_pkg;

  localparam int SEL_W = 3;
  localparam int DEC_W = 1 << SEL_W;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [DEC_W-1:0] dec_t;

endpackage

// File: rtl/dec3_to_8_core.sv
// Unregistered binary-to-one-hot decode; reusable wherever a raw select decode is needed.
module dec3_to_8_core
  import cpu_pkg::*;
(
  input  sel_t i_a,
  output dec_t o_onehot
);

  always_comb begin
    o_onehot = '0;
    o_onehot[i_a] = 1'b1;
  end

endmodule

// File: rtl/dec3_to_8_sync.sv
// Registered 3-to-8 decoder with enable gating, optional one-cold output and a valid flag.
module dec3_to_8_sync
  import cpu_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [SEL_W-1:0] i_a,
  output logic [DEC_W-1:0] o_y,
  output logic             o_valid
);

  // XOR mask doubles as the all-inactive value for the chosen polarity.
  localparam dec_t INACTIVE = {DEC_W{OUT_ACTIVE_LOW}};

  dec_t w_onehot;
  dec_t r_y;
  logic r_valid;

  dec3_to_8_core u_core (
    .i_a      (i_a),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y     <= INACTIVE;
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_y     <= w_onehot ^ INACTIVE;
      r_valid <= 1'b1;
    end else begin
      r_y     <= INACTIVE;
      r_valid <= 1'b0;
    end
  end

  assign o_y     = r_y;
  assign o_valid = r_valid;

  a_valid_onehot : assert property (@(posedge i_clk) disable iff (i_rst)
    r_valid |-> $onehot(r_y ^ INACTIVE));

endmodule

// File: tb/tb_dec3_to_8_sync.sv
// Directed plus random stimulus on active-high and active-low decoders against an arithmetic model.
module tb_dec3_to_8_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [2:0] a   = 3'd0;

  logic [7:0] y_hi, y_lo;
  logic       valid_hi, valid_lo;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dec3_to_8_sync #(.OUT_ACTIVE_LOW(1'b0)) u_dut_hi (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_a(a), .o_y(y_hi), .o_valid(valid_hi)
  );

  dec3_to_8_sync #(.OUT_ACTIVE_LOW(1'b1)) u_dut_lo (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_a(a), .o_y(y_lo), .o_valid(valid_lo)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare both DUTs with the model.
  task automatic step(input string tag, input logic s_rst, input logic s_en, input logic [2:0] s_a);
    logic [7:0] exp_y;
    logic       exp_valid;
    @(negedge clk);
    rst = s_rst;
    en  = s_en;
    a   = s_a;
    exp_valid = !s_rst && s_en;
    exp_y     = exp_valid ? 8'(2 ** int'(s_a)) : 8'd0;
    @(posedge clk);
    #1;
    check({tag, "_y"},        y_hi,             exp_y);
    check({tag, "_valid"},    {7'd0, valid_hi}, {7'd0, exp_valid});
    check({tag, "_ylow"},     y_lo,             ~exp_y);
    check({tag, "_validlow"}, {7'd0, valid_lo}, {7'd0, exp_valid});
    if (exp_valid)
      check({tag, "_popcount"}, 8'($countones(y_hi)), 8'd1);
  endtask

  initial begin
    // Reset held with enable active and a pending code
    step("rst0", 1'b1, 1'b1, 3'b101);
    step("rst1", 1'b1, 1'b1, 3'b101);
    step("rel",  1'b0, 1'b1, 3'b101);

    // Back-to-back sequence
    step("seq0", 1'b0, 1'b1, 3'b001);
    step("seq1", 1'b0, 1'b1, 3'b000);
    step("seq2", 1'b0, 1'b1, 3'b001);
    step("seq3", 1'b0, 1'b1, 3'b010);

    // Exhaustive sweep
    for (int i = 0; i < 8; i++)
      step($sformatf("sweep%0d", i), 1'b0, 1'b1, 3'(i));

    // Enable gating: disabled cycle clears, not holds
    step("en_on",  1'b0, 1'b1, 3'b011);
    step("en_off", 1'b0, 1'b0, 3'b110);
    step("en_re",  1'b0, 1'b1, 3'b110);

    // Reset mid-stream
    step("mid0",   1'b0, 1'b1, 3'b111);
    step("midrst", 1'b1, 1'b1, 3'b111);
    step("mid1",   1'b0, 1'b1, 3'b111);

    // Random traffic with occasional reset and disable
    for (int i = 0; i < 60; i++)
      step($sformatf("rnd%0d", i), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
